hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

- Generates every stall and flush control for the five-stage RV32 pipeline registers: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- It is the producer side of the flush/stall interface those registers consume:
  - a stalled register holds its contents;
  - a flushed register loads a NOP or zero bubble.
- Resolves four hazards by fixed priority: data-memory wait, multi-cycle MUL/DIV occupancy, taken branch/jump, and load-use.
- Keeps 32-bit stall and flush performance counters.

## Interface
Parameters:
- MDU_LAT, default 8: cycles a MUL/DIV instruction occupies EX. Legal range 1..256.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- rs1_ID, rs2_ID  in  5  source register numbers of the instruction in ID.
- rs1_used_ID, rs2_used_ID  in  1  the instruction in ID actually reads rs1 / rs2.
- rd_EX  in  5  destination register of the instruction in EX.
- mem_read_EX  in  1  the instruction in EX is a load.
- mdu_op_EX  in  1  the instruction in EX is MUL/DIV.
- branch_taken_EX  in  1  branch or jump resolved taken in EX.
- mem_req_MEM, mem_ready_MEM  in  1  data-memory request and completion for the instruction in MEM.
- pc_stall  out  1  hold the PC register.
- if_id_stall, if_id_flush  out  1  IF/ID register controls.
- id_ex_stall, id_ex_flush  out  1  ID/EX register controls.
- ex_mem_stall, ex_mem_flush  out  1  EX/MEM register controls.
- mem_wb_flush  out  1  insert a bubble into MEM/WB.
- mdu_busy  out  1  high while the MDU state is MDU_WAIT.
- stall_cnt  out  32  count of cycles with pc_stall=1.
- flush_cnt  out  32  count of cycles with a branch flush applied.

## Operation
Conditions, all combinational from the inputs:
- memw = mem_req_MEM & ~mem_ready_MEM.
- lu = mem_read_EX & rd_EX≠0 & ((rs1_used_ID & rs1_ID==rd_EX) | (rs2_used_ID & rs2_ID==rd_EX)).
- mdu_hold:
  - in RUN: mdu_op_EX & MDU_LAT>1;
  - in MDU_WAIT: cnt≠0.

Priority and resulting outputs; every output not listed is 0:
1. memw:
   - pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_flush = 1.
   - Branch, load-use and MDU release are all deferred.
2. MDU not released, i.e. mdu_hold, or MDU_WAIT with cnt==0 but memw:
   - pc_stall, if_id_stall, id_ex_stall = 1; ex_mem_flush = 1.
3. branch_taken_EX: if_id_flush, id_ex_flush = 1.
4. lu: pc_stall, if_id_stall = 1; id_ex_flush = 1.

Invariant: for any register, stall and flush are never both 1 in the same cycle.

MDU state machine:
- States RUN and MDU_WAIT. Down-counter cnt, width clog2(MDU_LAT).
- RUN with mdu_op_EX, MDU_LAT>1 and ~memw: go to MDU_WAIT, cnt ← MDU_LAT-2.
- MDU_WAIT:
  - cnt decrements every cycle and saturates at 0; it keeps counting even while memw.
  - cnt==0 and ~memw: release (no MDU stall this cycle), next state RUN.
- MDU_LAT=1: never leaves RUN and never stalls.
- Result: a MUL/DIV stays in EX exactly MDU_LAT cycles and causes MDU_LAT-1 stall cycles, when memw is absent.
- Back-to-back MUL/DIV: the release cycle returns to RUN; the next MUL/DIV entering EX re-triggers.

Counters:
- stall_cnt increments when pc_stall=1.
- flush_cnt increments when the priority-3 branch flush is applied.
- Both wrap modulo 2^32.

## Timing
- Stall/flush outputs are combinational from the inputs and current state; they are valid in the same cycle and sampled by the pipeline registers at the next edge.
- Only state, cnt, stall_cnt and flush_cnt are registered.
- While rst=1:
  - all stall/flush outputs and mdu_busy are forced to 0;
  - at the edge, state ← RUN, cnt ← 0, stall_cnt ← 0, flush_cnt ← 0.
- Reset during MDU_WAIT: mdu_busy=0 from the first cycle after the edge.
- Load-use costs exactly 1 bubble: the following cycle the load is in MEM, so lu clears.
- Taken branch costs exactly 2 flushed slots.
- memw for N cycles stretches everything by N, with N bubbles entering WB.

## Test plan
- Load-use: lw x5 in EX (rd_EX=5, mem_read_EX=1), add x6,x5,x1 in ID (rs1_ID=5, rs1_used_ID=1):
  - pc_stall=if_id_stall=id_ex_flush=1 for exactly 1 cycle;
  - with rd_EX=0 instead: all outputs 0.
- Branch: branch_taken_EX=1 for 1 cycle → if_id_flush=id_ex_flush=1 that cycle; flush_cnt goes 0→1.
- MDU, MDU_LAT=8: mdu_op_EX held high until release:
  - pc_stall/id_ex_stall/ex_mem_flush = 1 for exactly 7 cycles;
  - mdu_busy = 1 for 7 cycles (the 6 stalled cycles in MDU_WAIT plus the release cycle);
  - stall_cnt = 7.
- Memory wait overlapping MDU:
  - mem_req_MEM=1, mem_ready_MEM=0 for 3 cycles overlapping the MDU release;
  - all four stalls=1 and mem_wb_flush=1 for those 3 cycles;
  - MDU releases the first cycle memw=0;
  - a simultaneous branch_taken_EX produces no flush until memw=0.
- Priority with lu and branch both set: if_id_flush=id_ex_flush=1, pc_stall=0, id_ex_stall=0.
- Reset: assert rst at the 3rd MDU_WAIT cycle:
  - outputs are 0 while rst=1;
  - after the edge, state is RUN, counters read 0, mdu_busy=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall/flush control for the five-stage RV32 pipeline registers, with MUL/DIV
// occupancy tracking and stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned MDU_LAT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_ID,
    input  logic [4:0]  rs2_ID,
    input  logic        rs1_used_ID,
    input  logic        rs2_used_ID,
    input  logic [4:0]  rd_EX,
    input  logic        mem_read_EX,
    input  logic        mdu_op_EX,
    input  logic        branch_taken_EX,
    input  logic        mem_req_MEM,
    input  logic        mem_ready_MEM,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        mdu_busy,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam int unsigned CntW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam bit MduMulti = (MDU_LAT > 1);
    localparam logic [CntW-1:0] CntLoad = (MDU_LAT > 1) ? CntW'(MDU_LAT - 2) : '0;

    typedef enum logic {StRun, StMduWait} state_e;

    state_e        state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]   stall_cnt_q, stall_cnt_d;
    logic [31:0]   flush_cnt_q, flush_cnt_d;

    logic memw, lu, mdu_hold, mdu_block, flush_apply;

    always_comb begin
        memw = mem_req_MEM & ~mem_ready_MEM;
        lu   = mem_read_EX & (rd_EX != 5'd0) &
               ((rs1_used_ID & (rs1_ID == rd_EX)) | (rs2_used_ID & (rs2_ID == rd_EX)));
        mdu_hold = (state_q == StRun) ? (mdu_op_EX & MduMulti) : (cnt_q != '0);
        // An expired MDU count is only released once memory is no longer waiting.
        mdu_block = mdu_hold | ((state_q == StMduWait) & (cnt_q == '0) & memw);
    end

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        flush_apply  = 1'b0;
        if (!rst) begin
            if (memw) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (mdu_block) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (branch_taken_EX) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                flush_apply  = 1'b1;
            end else if (lu) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_flush  = 1'b1;
            end
        end
        mdu_busy = (state_q == StMduWait) & ~rst;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q + 32'(pc_stall);
        flush_cnt_d = flush_cnt_q + 32'(flush_apply);
        case (state_q)
            StRun: begin
                if (mdu_op_EX && MduMulti && !memw) begin
                    state_d = StMduWait;
                    cnt_d   = CntLoad;
                end
            end
            StMduWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (!memw) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MDU_LAT=8): load-use, branch, MDU, memory wait, reset.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_ID, rs2_ID, rd_EX;
    logic        rs1_used_ID, rs2_used_ID, mem_read_EX, mdu_op_EX, branch_taken_EX;
    logic        mem_req_MEM, mem_ready_MEM;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, ex_mem_flush, mem_wb_flush, mdu_busy;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Packed view: {pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_f, busy}
    localparam logic [8:0] ONone   = 9'h000;
    localparam logic [8:0] OLu     = 9'h190;
    localparam logic [8:0] OBr     = 9'h050;
    localparam logic [8:0] OMdu    = 9'h1A4;
    localparam logic [8:0] OMemw   = 9'h1AA;
    localparam logic [8:0] OBusy   = 9'h001;

    hazard_ctrl #(.MDU_LAT(8)) dut (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_EX(rd_EX), .mem_read_EX(mem_read_EX), .mdu_op_EX(mdu_op_EX),
        .branch_taken_EX(branch_taken_EX),
        .mem_req_MEM(mem_req_MEM), .mem_ready_MEM(mem_ready_MEM),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush), .mdu_busy(mdu_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                ex_mem_stall, ex_mem_flush, mem_wb_flush, mdu_busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge, checks 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1_ID = 0; rs2_ID = 0; rd_EX = 0;
        rs1_used_ID = 0; rs2_used_ID = 0; mem_read_EX = 0; mdu_op_EX = 0;
        branch_taken_EX = 0; mem_req_MEM = 0; mem_ready_MEM = 0;
    endtask

    initial begin
        // Reset, with a MUL/DIV request that must be masked.
        idle_inputs();
        rst = 1'b1;
        mdu_op_EX = 1'b1;
        #1;
        chk("rst_outs", 32'(outs()), 32'(ONone));
        tick();
        tick();
        rst = 1'b0;
        mdu_op_EX = 1'b0;
        #1;
        chk("rst_idle_outs", 32'(outs()), 32'(ONone));
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);

        // Load-use via rs1.
        rd_EX = 5'd5; mem_read_EX = 1'b1; rs1_ID = 5'd5; rs1_used_ID = 1'b1;
        #1 chk("lu_rs1", 32'(outs()), 32'(OLu));
        tick();
        mem_read_EX = 1'b0; rd_EX = 5'd0;
        #1 chk("lu_clears", 32'(outs()), 32'(ONone));
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        // Load to x0 never interlocks.
        mem_read_EX = 1'b1; rd_EX = 5'd0; rs1_ID = 5'd0;
        #1 chk("lu_x0", 32'(outs()), 32'(ONone));
        // Load-use via rs2; rs1 matches but is unused.
        rd_EX = 5'd7; rs1_ID = 5'd7; rs1_used_ID = 1'b0; rs2_ID = 5'd7; rs2_used_ID = 1'b1;
        #1 chk("lu_rs2", 32'(outs()), 32'(OLu));
        rs2_used_ID = 1'b0;
        #1 chk("lu_unused", 32'(outs()), 32'(ONone));
        rs2_used_ID = 1'b1;
        tick();
        chk("lu2_stall_cnt", stall_cnt, 32'd2);
        idle_inputs();

        // Taken branch.
        branch_taken_EX = 1'b1;
        #1 chk("br_outs", 32'(outs()), 32'(OBr));
        chk("br_flush_cnt0", flush_cnt, 32'd0);
        tick();
        branch_taken_EX = 1'b0;
        #1 chk("br_flush_cnt1", flush_cnt, 32'd1);

        // Branch beats load-use.
        branch_taken_EX = 1'b1;
        rd_EX = 5'd3; mem_read_EX = 1'b1; rs1_ID = 5'd3; rs1_used_ID = 1'b1;
        #1 chk("br_over_lu", 32'(outs()), 32'(OBr));
        tick();
        idle_inputs();
        #1 chk("br_lu_flush_cnt", flush_cnt, 32'd2);
        chk("br_lu_stall_cnt", stall_cnt, 32'd2);

        // MUL/DIV: 7 stall cycles, busy on cycles 1..7, release on cycle 7.
        mdu_op_EX = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 chk($sformatf("mdu_c%0d", i), 32'(outs()),
                   32'(((i < 7) ? OMdu : ONone) | ((i > 0) ? OBusy : ONone)));
            tick();
        end
        mdu_op_EX = 1'b0;
        #1 chk("mdu_after", 32'(outs()), 32'(ONone));
        chk("mdu_stall_cnt", stall_cnt, 32'd9);

        // MUL/DIV with memory wait on cycles 6..8 and a branch pending on 6..9.
        mdu_op_EX = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [8:0] exp;
            mem_req_MEM     = (i >= 6 && i <= 8);
            branch_taken_EX = (i >= 6);
            if (i < 6)       exp = OMdu | ((i > 0) ? OBusy : ONone);
            else if (i < 9)  exp = OMemw | OBusy;
            else             exp = OBr | OBusy;
            #1 chk($sformatf("memw_c%0d", i), 32'(outs()), 32'(exp));
            tick();
        end
        idle_inputs();
        #1 chk("memw_after", 32'(outs()), 32'(ONone));
        chk("memw_stall_cnt", stall_cnt, 32'd18);
        chk("memw_flush_cnt", flush_cnt, 32'd3);

        // Reset on the third MDU_WAIT cycle.
        mdu_op_EX = 1'b1;
        tick();
        tick();
        tick();
        #1 chk("pre_rst_busy", 32'(outs()), 32'(OMdu | OBusy));
        chk("pre_rst_stall_cnt", stall_cnt, 32'd21);
        rst = 1'b1;
        #1 chk("in_rst_outs", 32'(outs()), 32'(ONone));
        tick();
        rst = 1'b0;
        mdu_op_EX = 1'b0;
        #1 chk("post_rst_outs", 32'(outs()), 32'(ONone));
        chk("post_rst_stall_cnt", stall_cnt, 32'd0);
        chk("post_rst_flush_cnt", flush_cnt, 32'd0);
        tick();
        chk("post_rst_idle", 32'(outs()), 32'(ONone));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
